uart_tx_fsm: RTL and testbench

UART_TX_FSM -- requirements
Module: uart_tx_fsm

---
 rtl/uart_tx_fsm.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fsm.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm
//   UART transmitter with CTS flow control. Each frame is sent as
//   start(0), DATA_BITS data bits MSB first, even parity, STOP_BITS stop(1).
//   Every bit is held for CLKS_PER_BIT = SYSCLOCK_FREQ / BAUDRATE clocks,
//   which must be at least 2.
//
// Ports
//   Clk        in   system clock, rising-edge active
//   Rst        in   asynchronous active-high reset; aborts any frame in flight
//   Tx_Data_In in   byte to send, latched when it is accepted
//   Tx_Valid   in   upstream has a byte on Tx_Data_In
//   CTS        in   remote receiver ready (far-end RTS)
//   Tx_Ready   out  byte is accepted on the next edge if Tx_Valid is high
//   Tx_Out     out  serial line, idle high, registered
//   Tx_Busy    out  frame in progress
//   Tx_Done    out  one-cycle pulse on the first idle cycle after a frame
module uart_tx_fsm #(
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 2,
  parameter int SYSCLOCK_FREQ = 100000,
  parameter int BAUDRATE      = 9600
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Tx_Data_In,
  input  logic                 Tx_Valid,
  input  logic                 CTS,
  output logic                 Tx_Ready,
  output logic                 Tx_Out,
  output logic                 Tx_Busy,
  output logic                 Tx_Done
);

  localparam int CLKS_PER_BIT = SYSCLOCK_FREQ / BAUDRATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int MAX_BITS     = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int IDX_W        = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_out_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 bit_end_d;

  // Ready is combinational so a byte can be taken in the same cycle
  // Tx_Done is high; forcing it low under Rst keeps upstream from
  // believing a byte was taken while the block is held in reset.
  assign Tx_Ready  = (state_q == IDLE) && CTS && !Rst;
  assign bit_end_d = (cnt_q == CNT_LAST);

  assign Tx_Out  = tx_out_q;
  assign Tx_Busy = busy_q;
  assign Tx_Done = done_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Bit-period counter runs in every active state and wraps at the
      // end of each bit; state decisions below key off bit_end_d.
      if (state_q != IDLE) begin
        cnt_q <= bit_end_d ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (Tx_Valid && Tx_Ready) begin
            shift_q  <= Tx_Data_In;
            parity_q <= ^Tx_Data_In;
            tx_out_q <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= START;
          end
        end

        START: begin
          if (bit_end_d) begin
            tx_out_q <= shift_q[DATA_BITS-1];
            shift_q  <= shift_q << 1;
            idx_q    <= '0;
            state_q  <= DATA;
          end
        end

        DATA: begin
          if (bit_end_d) begin
            if (idx_q == DATA_LAST) begin
              tx_out_q <= parity_q;
              state_q  <= PARITY;
            end else begin
              tx_out_q <= shift_q[DATA_BITS-1];
              shift_q  <= shift_q << 1;
              idx_q    <= idx_q + 1'b1;
            end
          end
        end

        PARITY: begin
          if (bit_end_d) begin
            tx_out_q <= 1'b1;
            idx_q    <= '0;
            state_q  <= STOP;
          end
        end

        STOP: begin
          if (bit_end_d) begin
            if (idx_q == STOP_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        default: begin
          tx_out_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
module tb_uart_tx_fsm;

  localparam int NBITS = 12;
  localparam int CPB   = 10;
  localparam int FRAME = NBITS * CPB;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] Tx_Data_In;
  logic       Tx_Valid;
  logic       CTS;
  logic       Tx_Ready;
  logic       Tx_Out;
  logic       Tx_Busy;
  logic       Tx_Done;

  uart_tx_fsm #(
    .DATA_BITS    (8),
    .STOP_BITS    (2),
    .SYSCLOCK_FREQ(100000),
    .BAUDRATE     (9600)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Tx_Data_In(Tx_Data_In),
    .Tx_Valid  (Tx_Valid),
    .CTS       (CTS),
    .Tx_Ready  (Tx_Ready),
    .Tx_Out    (Tx_Out),
    .Tx_Busy   (Tx_Busy),
    .Tx_Done   (Tx_Done)
  );

  always #5 Clk = ~Clk;

  int tests_run = 0;
  int fails     = 0;
  int cyc_now   = 0;

  always @(posedge Clk) cyc_now <= cyc_now + 1;

  // line holds the sampled bit values in time order, start bit in the MSB
  typedef struct {
    logic [NBITS-1:0] line;
    logic             hold_ok;
    logic             busy_ok;
    logic             done_ok;
    int               t0;
  } frame_t;

  frame_t     rx_q[$];
  logic [7:0] exp_q[$];

  // Line monitor: samples on the falling edge, reconstructs each frame
  // from its first low sample, and checks bit hold, Busy and Done timing.
  logic   mact = 1'b0;
  int     mcyc = 0;
  frame_t mf;
  int     done_cnt  = 0;
  int     rdy_extra = 0;
  logic   meas_rdy  = 1'b0;

  always @(negedge Clk) begin
    if (Tx_Done === 1'b1) done_cnt++;
    if (meas_rdy && Tx_Ready === 1'b1 && Tx_Done !== 1'b1) rdy_extra++;
    if (Rst !== 1'b0) begin
      mact = 1'b0;
    end else begin
      if (!mact && Tx_Out === 1'b0) begin
        mact       = 1'b1;
        mcyc       = 0;
        mf.line    = '0;
        mf.hold_ok = 1'b1;
        mf.busy_ok = 1'b1;
        mf.done_ok = 1'b0;
        mf.t0      = cyc_now;
      end
      if (mact) begin
        if (mcyc < FRAME) begin
          if (mcyc % CPB == 0) mf.line[NBITS-1-mcyc/CPB] = Tx_Out;
          else if (Tx_Out !== mf.line[NBITS-1-mcyc/CPB]) mf.hold_ok = 1'b0;
          if (Tx_Busy !== 1'b1) mf.busy_ok = 1'b0;
          mcyc++;
        end else begin
          mf.done_ok = (Tx_Done === 1'b1);
          if (Tx_Busy !== 1'b0 || Tx_Out !== 1'b1) mf.busy_ok = 1'b0;
          rx_q.push_back(mf);
          mact = 1'b0;
        end
      end
    end
  end

  function automatic logic [14:0] pack(input frame_t f);
    return {f.line, f.hold_ok, f.busy_ok, f.done_ok};
  endfunction

  function automatic logic [14:0] want(input logic [7:0] e);
    return {1'b0, e, ^e, 2'b11, 3'b111};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    while (Tx_Ready !== 1'b1 && k < 400) begin
      tick(1);
      k++;
    end
    tests_run++;
    if (Tx_Ready !== 1'b1) begin
      fails++;
      $display("FAIL send_accept: Tx_Ready=%b after %0d cycles, required 1", Tx_Ready, k);
    end
    Tx_Data_In = b;
    Tx_Valid   = 1'b1;
    exp_q.push_back(b);
    tick(1);
    Tx_Valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    tests_run++;
    if (rx_q.size() < n) begin
      fails++;
      $display("FAIL frame_timeout: got %0d frames, required %0d", rx_q.size(), n);
    end
  endtask

  task automatic pop_frame(output frame_t f, output logic [7:0] e);
    if (rx_q.size() > 0) f = rx_q.pop_front();
    else begin
      f.line = 'x; f.hold_ok = 1'bx; f.busy_ok = 1'bx; f.done_ok = 1'bx; f.t0 = 0;
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset;
    Rst = 1'b1; CTS = 1'b1; Tx_Valid = 1'b1; Tx_Data_In = 8'h5A;
    tick(3);
    tests_run++;
    if ({Tx_Out, Tx_Busy, Tx_Done, Tx_Ready} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_outputs: Out/Busy/Done/Ready=%b, required 1000",
               {Tx_Out, Tx_Busy, Tx_Done, Tx_Ready});
    end
    Tx_Valid = 1'b0;
    Rst = 1'b0;
    #1;
    tests_run++;
    if (Tx_Ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: Tx_Ready=%b, required 1", Tx_Ready);
    end
    tick(3);
    tests_run++;
    if ({Tx_Out, Tx_Busy} !== 2'b10) begin
      fails++;
      $display("FAIL idle_no_valid: Out/Busy=%b, required 10", {Tx_Out, Tx_Busy});
    end
  endtask

  task automatic test_a5;
    frame_t f; logic [7:0] e; int d0;
    d0 = done_cnt;
    send_byte(8'hA5);
    tick(5);
    tests_run++;
    if ({Tx_Busy, Tx_Ready} !== 2'b10) begin
      fails++;
      $display("FAIL a5_busy: Busy/Ready=%b, required 10", {Tx_Busy, Tx_Ready});
    end
    wait_frames(1, 200);
    pop_frame(f, e);
    tests_run++;
    if (pack(f) !== {12'b0_10100101_0_11, 3'b111}) begin
      fails++;
      $display("FAIL a5_frame: got %h, required %h", pack(f), {12'b0_10100101_0_11, 3'b111});
    end
    tick(3);
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL a5_done_count: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_parity;
    frame_t f; logic [7:0] e;
    send_byte(8'h01);
    wait_frames(1, 200);
    pop_frame(f, e);
    tests_run++;
    if (pack(f) !== 15'b0_00000001_1_11_111) begin
      fails++;
      $display("FAIL parity_01: got %h, required %h", pack(f), 15'b0_00000001_1_11_111);
    end
    send_byte(8'h00);
    wait_frames(1, 200);
    pop_frame(f, e);
    tests_run++;
    if (pack(f) !== 15'b0_00000000_0_11_111) begin
      fails++;
      $display("FAIL parity_00: got %h, required %h", pack(f), 15'b0_00000000_0_11_111);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    frame_t fr [3];
    logic [7:0] e;
    int idx = 0;
    int k = 0;
    int d0;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    d0 = done_cnt;
    rdy_extra = 0;
    CTS = 1'b1;
    Tx_Data_In = bytes[0];
    Tx_Valid = 1'b1;
    while (idx < 3 && k < 600) begin
      if (Tx_Ready === 1'b1) begin
        exp_q.push_back(bytes[idx]);
        tick(1);
        meas_rdy = 1'b1;
        idx++;
        // Change the input immediately: a busy transmitter must ignore it
        if (idx < 3) Tx_Data_In = bytes[idx];
        else begin
          Tx_Valid = 1'b0;
          Tx_Data_In = 8'hFF;
        end
      end else begin
        tick(1);
      end
      k++;
    end
    wait_frames(3, 500);
    meas_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pop_frame(fr[i], e);
      tests_run++;
      if (pack(fr[i]) !== want(e)) begin
        fails++;
        $display("FAIL b2b_frame%0d: got %h, required %h", i, pack(fr[i]), want(e));
      end
    end
    for (int i = 1; i < 3; i++) begin
      tests_run++;
      if (fr[i].t0 - fr[i-1].t0 - 100 !== 21) begin
        fails++;
        $display("FAIL b2b_gap%0d: got %0d high cycles, required 21", i, fr[i].t0 - fr[i-1].t0 - 100);
      end
    end
    tests_run++;
    if (rdy_extra !== 0) begin
      fails++;
      $display("FAIL b2b_ready: Tx_Ready high outside Done cycles %0d times, required 0", rdy_extra);
    end
    tests_run++;
    if (done_cnt - d0 !== 3) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d, required 3", done_cnt - d0);
    end
  endtask

  task automatic test_cts;
    frame_t f; logic [7:0] e;
    int bad = 0;
    CTS = 1'b0; Tx_Valid = 1'b1; Tx_Data_In = 8'h77;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (Tx_Ready !== 1'b0 || Tx_Out !== 1'b1 || Tx_Busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0 || rx_q.size() !== 0) begin
      fails++;
      $display("FAIL cts_block: %0d bad cycles, %0d frames, required 0 and 0", bad, rx_q.size());
    end
    Tx_Valid = 1'b0;
    CTS = 1'b1;
    send_byte(8'h96);
    tick(30);
    CTS = 1'b0;
    Tx_Valid = 1'b1;
    Tx_Data_In = 8'h69;
    wait_frames(1, 200);
    pop_frame(f, e);
    tests_run++;
    if (pack(f) !== want(e)) begin
      fails++;
      $display("FAIL cts_midframe: got %h, required %h", pack(f), want(e));
    end
    tick(300);
    tests_run++;
    if (rx_q.size() !== 0 || Tx_Busy !== 1'b0 || Tx_Out !== 1'b1) begin
      fails++;
      $display("FAIL cts_no_next: frames=%0d Busy=%b Out=%b, required 0 0 1", rx_q.size(), Tx_Busy, Tx_Out);
    end
    Tx_Valid = 1'b0;
    CTS = 1'b1;
  endtask

  task automatic test_reset_mid;
    frame_t f; logic [7:0] e;
    int d0;
    send_byte(8'h00);
    tick(49);
    tests_run++;
    if ({Tx_Out, Tx_Busy} !== 2'b01) begin
      fails++;
      $display("FAIL rst_mid_pre: Out/Busy=%b, required 01", {Tx_Out, Tx_Busy});
    end
    d0 = done_cnt;
    #2;
    Rst = 1'b1;
    #1;
    tests_run++;
    if ({Tx_Out, Tx_Busy, Tx_Done, Tx_Ready} !== 4'b1000) begin
      fails++;
      $display("FAIL rst_mid_async: Out/Busy/Done/Ready=%b, required 1000",
               {Tx_Out, Tx_Busy, Tx_Done, Tx_Ready});
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    void'(exp_q.pop_back());
    #1;
    tests_run++;
    if (Tx_Ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_ready: Tx_Ready=%b, required 1", Tx_Ready);
    end
    tick(200);
    tests_run++;
    if (done_cnt !== d0 || rx_q.size() !== 0) begin
      fails++;
      $display("FAIL rst_mid_abort: %0d Done pulses, %0d frames, required 0 and 0", done_cnt - d0, rx_q.size());
    end
    send_byte(8'hC3);
    wait_frames(1, 200);
    pop_frame(f, e);
    tests_run++;
    if (pack(f) !== want(e)) begin
      fails++;
      $display("FAIL rst_mid_next: got %h, required %h", pack(f), want(e));
    end
  endtask

  task automatic test_loopback;
    logic [7:0] bytes [4];
    frame_t f; logic [7:0] e;
    int d0;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'hA5; bytes[3] = 8'h5A;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) send_byte(bytes[i]);
    wait_frames(4, 300);
    for (int i = 0; i < 4; i++) begin
      pop_frame(f, e);
      tests_run++;
      if (pack(f) !== want(e)) begin
        fails++;
        $display("FAIL loop_%0d: got %h, required %h", i, pack(f), want(e));
      end
    end
    tick(3);
    tests_run++;
    if (done_cnt - d0 !== 4) begin
      fails++;
      $display("FAIL loop_done_count: got %0d, required 4", done_cnt - d0);
    end
  endtask

  initial begin
    Rst = 1'b1; CTS = 1'b0; Tx_Valid = 1'b0; Tx_Data_In = 8'h00;
    test_reset;
    test_a5;
    test_parity;
    test_back_to_back;
    test_cts;
    test_reset_mid;
    test_loopback;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1);
  end

endmodule
